// File: rtl/decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_pkg: opcode constants, control record and opcode classifier  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package decode_pkg;

  localparam logic [6:0] C_OP_R      = 7'b0110011;
  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic     uses_rs1;
    logic     uses_rs2;
    logic     rd_write;
    logic     mem_read;
    logic     mem_write;
    logic     illegal;
    imm_fmt_e imm_fmt;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
    ctrl_t c;
    c = '0;
    c.imm_fmt = IMM_NONE;
    case (opcode)
      C_OP_R: begin
        c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.rd_write = 1'b1;
      end
      C_OP_IMM: begin
        c.uses_rs1 = 1'b1; c.rd_write = 1'b1; c.imm_fmt = IMM_I;
      end
      C_OP_LOAD: begin
        c.uses_rs1 = 1'b1; c.rd_write = 1'b1; c.mem_read = 1'b1; c.imm_fmt = IMM_I;
      end
      C_OP_STORE: begin
        c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.mem_write = 1'b1; c.imm_fmt = IMM_S;
      end
      C_OP_BRANCH: begin
        c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.imm_fmt = IMM_B;
      end
      C_OP_LUI, C_OP_AUIPC: begin
        c.rd_write = 1'b1; c.imm_fmt = IMM_U;
      end
      C_OP_JAL: begin
        c.rd_write = 1'b1; c.imm_fmt = IMM_J;
      end
      C_OP_JALR: begin
        c.uses_rs1 = 1'b1; c.rd_write = 1'b1; c.imm_fmt = IMM_I;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_bypass: 2R/1W integer register file, optional WB forwarding |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_bypass #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic            req,
  input  logic            reset,
  input  logic [4:0]      i_rs1_idx,
  input  logic [4:0]      i_rs2_idx,
  output logic [XLEN-1:0] o_rs1_val,
  output logic [XLEN-1:0] o_rs2_val,
  input  logic            i_wb_write,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_value
);

  localparam int C_AW = $clog2(NREGS);

  logic [XLEN-1:0] r_regs [NREGS];

  // Indices beyond the implemented file read as zero; decode flags them illegal.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
    logic [XLEN-1:0] v;
    v = '0;
    if (idx != 5'd0 && 32'(idx) < NREGS) begin
      if (BYPASS != 0 && i_wb_write && i_wb_rd == idx) v = i_wb_value;
      else                                              v = r_regs[idx[C_AW-1:0]];
    end
    return v;
  endfunction

  always_comb o_rs1_val = read_port(i_rs1_idx);
  always_comb o_rs2_val = read_port(i_rs2_idx);

  always_ff @(posedge req) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_wb_write && i_wb_rd != 5'd0 && 32'(i_wb_rd) < NREGS) begin
      r_regs[i_wb_rd[C_AW-1:0]] <= i_wb_value;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_stage: RV32I/E decode with regfile, hazard and ID/EX register |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic            req,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            wb_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_value,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic [6:0]      alu_op_out,
  output logic [4:0]      rd_out,
  output logic            rd_write_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic [XLEN-1:0] rs1_value_out,
  output logic [XLEN-1:0] rs2_value_out,
  output logic [XLEN-1:0] imm_value_out,
  output logic            illegal_out
);

  logic [4:0]      w_rs1, w_rs2, w_rd;
  ctrl_t           w_ctrl;
  logic            w_bad_idx, w_illegal, w_hazard, w_adv, w_accept;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val;

  logic            r_out_valid, r_rd_write, r_mem_read, r_mem_write, r_illegal;
  logic [XLEN-1:0] r_pc, r_rs1_val, r_rs2_val, r_imm;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7, r_opcode;
  logic [4:0]      r_rd;

  assign w_rs1  = instr_in[19:15];
  assign w_rs2  = instr_in[24:20];
  assign w_rd   = instr_in[11:7];
  assign w_ctrl = decode_ctrl(instr_in[6:0]);

  // Only indices the instruction actually uses can make it illegal on RV32E.
  assign w_bad_idx = (w_ctrl.uses_rs1 && 32'(w_rs1) >= NREGS) ||
                     (w_ctrl.uses_rs2 && 32'(w_rs2) >= NREGS) ||
                     (w_ctrl.rd_write && 32'(w_rd)  >= NREGS);
  assign w_illegal = w_ctrl.illegal || (instr_in[1:0] != 2'b11) || w_bad_idx;

  assign w_hazard = in_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((w_ctrl.uses_rs1 && w_rs1 == ex_rd) ||
                     (w_ctrl.uses_rs2 && w_rs2 == ex_rd));
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = flush || (w_adv && !w_hazard);
  assign w_accept = in_valid && w_adv && !w_hazard && !flush;

  always_comb begin
    w_imm32 = '0;
    case (w_ctrl.imm_fmt)
      IMM_I:   w_imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      IMM_S:   w_imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      IMM_B:   w_imm32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                          instr_in[30:25], instr_in[11:8], 1'b0};
      IMM_U:   w_imm32 = {instr_in[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                          instr_in[20], instr_in[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end
  assign w_imm = XLEN'($signed(w_imm32));

  regfile_bypass #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_regfile (
    .req        (req),
    .reset      (reset),
    .i_rs1_idx  (w_rs1),
    .i_rs2_idx  (w_rs2),
    .o_rs1_val  (w_rs1_val),
    .o_rs2_val  (w_rs2_val),
    .i_wb_write (wb_write),
    .i_wb_rd    (wb_rd),
    .i_wb_value (wb_value)
  );

  always_ff @(posedge req) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_pc        <= '0;
      r_funct3    <= '0;
      r_funct7    <= '0;
      r_opcode    <= '0;
      r_rd        <= '0;
      r_rd_write  <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_pc        <= pc_in;
        r_funct3    <= instr_in[14:12];
        r_funct7    <= instr_in[31:25];
        r_opcode    <= instr_in[6:0];
        r_rd        <= w_rd;
        r_rd_write  <= w_ctrl.rd_write && (w_rd != 5'd0) && !w_illegal;
        r_mem_read  <= w_ctrl.mem_read && !w_illegal;
        r_mem_write <= w_ctrl.mem_write && !w_illegal;
        r_rs1_val   <= w_rs1_val;
        r_rs2_val   <= w_ctrl.uses_rs2 ? w_rs2_val : '0;
        r_imm       <= w_imm;
        r_illegal   <= w_illegal;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign pc_out        = r_pc;
  assign funct3_out    = r_funct3;
  assign funct7_out    = r_funct7;
  assign alu_op_out    = r_opcode;
  assign rd_out        = r_rd;
  assign rd_write_out  = r_rd_write;
  assign mem_read_out  = r_mem_read;
  assign mem_write_out = r_mem_write;
  assign rs1_value_out = r_rs1_val;
  assign rs2_value_out = r_rs2_val;
  assign imm_value_out = r_imm;
  assign illegal_out   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_decode_stage: three configurations vs. a behavioural decode model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_decode_stage;

  localparam int C_N = 3;  // 0: default, 1: BYPASS=0, 2: NREGS=16

  logic        req = 1'b0;
  logic        reset, in_valid, wb_write, ex_mem_read, flush, out_ready;
  logic [31:0] instr_in, pc_in, wb_value;
  logic [4:0]  wb_rd, ex_rd;

  logic        d_rdy [C_N], d_val [C_N], d_rdw [C_N], d_mr [C_N], d_mw [C_N], d_ill [C_N];
  logic [31:0] d_pc [C_N], d_rs1 [C_N], d_rs2 [C_N], d_imm [C_N];
  logic [2:0]  d_f3 [C_N];
  logic [6:0]  d_f7 [C_N], d_op [C_N];
  logic [4:0]  d_rd [C_N];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 req = ~req;

  for (genvar g = 0; g < C_N; g++) begin : g_dut
    decode_stage #(
      .XLEN(32), .NREGS(g == 2 ? 16 : 32), .BYPASS(g == 1 ? 0 : 1)
    ) dut (
      .req(req), .reset(reset), .in_valid(in_valid), .in_ready(d_rdy[g]),
      .instr_in(instr_in), .pc_in(pc_in), .wb_write(wb_write), .wb_rd(wb_rd),
      .wb_value(wb_value), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush),
      .out_valid(d_val[g]), .out_ready(out_ready), .pc_out(d_pc[g]),
      .funct3_out(d_f3[g]), .funct7_out(d_f7[g]), .alu_op_out(d_op[g]),
      .rd_out(d_rd[g]), .rd_write_out(d_rdw[g]), .mem_read_out(d_mr[g]),
      .mem_write_out(d_mw[g]), .rs1_value_out(d_rs1[g]), .rs2_value_out(d_rs2[g]),
      .imm_value_out(d_imm[g]), .illegal_out(d_ill[g])
    );
  end

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // instruction classes: 0 unsupported, 1 R, 2 OP-IMM, 3 LOAD, 4 STORE,
  // 5 BRANCH, 6 LUI, 7 AUIPC, 8 JAL, 9 JALR
  function automatic int cls(input logic [31:0] ins);
    if (ins[1:0] != 2'b11) return 0;
    case (ins[6:0])
      7'h33: return 1;  7'h13: return 2;  7'h03: return 3;
      7'h23: return 4;  7'h63: return 5;  7'h37: return 6;
      7'h17: return 7;  7'h6F: return 8;  7'h67: return 9;
      default: return 0;
    endcase
  endfunction

  function automatic bit uses1(input int c); return c inside {1, 2, 3, 4, 5, 9}; endfunction
  function automatic bit uses2(input int c); return c inside {1, 4, 5}; endfunction
  function automatic bit writes(input int c); return c inside {1, 2, 3, 6, 7, 8, 9}; endfunction

  function automatic logic [31:0] mimm(input logic [31:0] ins);
    logic signed [31:0] s;
    logic [31:0] hi;
    s = $signed(ins);
    case (cls(ins))
      2, 3, 9: begin hi = s >>> 20; return hi; end
      4: begin hi = s >>> 25; return (hi << 5) | 32'(ins[11:7]); end
      5: begin
        hi = s >>> 31;
        return (hi << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      end
      6, 7: return ins & 32'hFFFF_F000;
      8: begin
        hi = s >>> 31;
        return (hi << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int nregs(input int k); return (k == 2) ? 16 : 32; endfunction

  logic [31:0] m_regs [C_N][32];
  logic        m_val [C_N], m_rdw [C_N], m_mr [C_N], m_mw [C_N], m_ill [C_N];
  logic [31:0] m_pc [C_N], m_rs1 [C_N], m_rs2 [C_N], m_imm [C_N];
  logic [2:0]  m_f3 [C_N];
  logic [6:0]  m_f7 [C_N], m_op [C_N];
  logic [4:0]  m_rd [C_N];

  function automatic logic [31:0] mread(input int k, input logic [4:0] idx);
    if (idx == 0 || int'(idx) >= nregs(k)) return 32'h0;
    if (k != 1 && wb_write && wb_rd == idx) return wb_value;
    return m_regs[k][idx];
  endfunction

  function automatic bit mhazard();
    int c;
    c = cls(instr_in);
    return in_valid && ex_mem_read && ex_rd != 0 &&
           ((uses1(c) && instr_in[19:15] == ex_rd) || (uses2(c) && instr_in[24:20] == ex_rd));
  endfunction

  always @(posedge req) begin
    int c;
    bit haz, ill, big;
    c   = cls(instr_in);
    haz = mhazard();
    for (int k = 0; k < C_N; k++) begin
      if (reset) begin
        m_val[k] = 0; m_pc[k] = 0; m_f3[k] = 0; m_f7[k] = 0; m_op[k] = 0; m_rd[k] = 0;
        m_rdw[k] = 0; m_mr[k] = 0; m_mw[k] = 0; m_rs1[k] = 0; m_rs2[k] = 0;
        m_imm[k] = 0; m_ill[k] = 0;
        for (int r = 0; r < 32; r++) m_regs[k][r] = 32'h0;
      end else begin
        if (flush) m_val[k] = 0;
        else if (!m_val[k] || out_ready) begin
          if (in_valid && !haz) begin
            big = (uses1(c) && int'(instr_in[19:15]) >= nregs(k)) ||
                  (uses2(c) && int'(instr_in[24:20]) >= nregs(k)) ||
                  (writes(c) && int'(instr_in[11:7]) >= nregs(k));
            ill = (c == 0) || big;
            m_val[k] = 1;
            m_pc[k]  = pc_in;
            m_f3[k]  = instr_in[14:12];
            m_f7[k]  = instr_in[31:25];
            m_op[k]  = instr_in[6:0];
            m_rd[k]  = instr_in[11:7];
            m_rdw[k] = writes(c) && instr_in[11:7] != 0 && !ill;
            m_mr[k]  = (c == 3) && !ill;
            m_mw[k]  = (c == 4) && !ill;
            m_rs1[k] = mread(k, instr_in[19:15]);
            m_rs2[k] = uses2(c) ? mread(k, instr_in[24:20]) : 32'h0;
            m_imm[k] = mimm(instr_in);
            m_ill[k] = ill;
          end else m_val[k] = 0;
        end
        if (wb_write && wb_rd != 0 && int'(wb_rd) < nregs(k)) m_regs[k][wb_rd] = wb_value;
      end
    end
    if (reset) chk_en = 1'b1;
  end

  always @(negedge req) begin
    if (chk_en) begin
      for (int k = 0; k < C_N; k++) begin
        chk("in_ready", k, 64'(d_rdy[k]), 64'(flush || ((!m_val[k] || out_ready) && !mhazard())));
        chk("out_valid", k, 64'(d_val[k]), 64'(m_val[k]));
        chk("pc", k, 64'(d_pc[k]), 64'(m_pc[k]));
        chk("funct3", k, 64'(d_f3[k]), 64'(m_f3[k]));
        chk("funct7", k, 64'(d_f7[k]), 64'(m_f7[k]));
        chk("opcode", k, 64'(d_op[k]), 64'(m_op[k]));
        chk("rd", k, 64'(d_rd[k]), 64'(m_rd[k]));
        chk("rd_write", k, 64'(d_rdw[k]), 64'(m_rdw[k]));
        chk("mem_read", k, 64'(d_mr[k]), 64'(m_mr[k]));
        chk("mem_write", k, 64'(d_mw[k]), 64'(m_mw[k]));
        chk("rs1_value", k, 64'(d_rs1[k]), 64'(m_rs1[k]));
        chk("rs2_value", k, 64'(d_rs2[k]), 64'(m_rs2[k]));
        chk("imm", k, 64'(d_imm[k]), 64'(m_imm[k]));
        chk("illegal", k, 64'(d_ill[k]), 64'(m_ill[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge req);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int p;
    w = $urandom;
    p = $urandom_range(0, 10);
    case (p)
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;  7: w[6:0] = 7'h6F;  8: w[6:0] = 7'h67;
      9: w[6:0] = 7'h0F;
      default: ;
    endcase
    if ($urandom_range(0, 4) != 0) begin
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
    end
    return w;
  endfunction

  initial begin
    reset = 1; in_valid = 0; instr_in = 0; pc_in = 0; wb_write = 0; wb_rd = 0;
    wb_value = 0; ex_mem_read = 0; ex_rd = 0; flush = 0; out_ready = 1;
    step(); step();
    reset = 0;
    #1;
    chk("rst_out_valid", 0, 64'(d_val[0]), 64'h0);
    chk("rst_imm", 0, 64'(d_imm[0]), 64'h0);
    chk("rst_in_ready", 0, 64'(d_rdy[0]), 64'h1);

    // ADD x6,x5,x0 : x5 reads zero after reset
    in_valid = 1; instr_in = 32'h0002_8333; pc_in = 32'h100;
    step();
    chk("x5_read", 0, 64'(d_rs1[0]), 64'h0);
    chk("add_rd", 0, 64'(d_rd[0]), 64'd6);

    // ADDI x4,x3,5 with x3 written back in the same cycle
    wb_write = 1; wb_rd = 3; wb_value = 32'h1234; instr_in = 32'h0051_8213; pc_in = 32'h104;
    step();
    wb_write = 0;
    chk("bypass_rs1", 0, 64'(d_rs1[0]), 64'h1234);
    chk("bypass_imm", 0, 64'(d_imm[0]), 64'd5);
    chk("bypass_rd", 0, 64'(d_rd[0]), 64'd4);
    chk("nobypass_rs1", 1, 64'(d_rs1[1]), 64'h0);

    // load-use: ADD x5,x3,x1 behind a load to x3
    ex_mem_read = 1; ex_rd = 3; instr_in = 32'h0011_82B3; pc_in = 32'h108;
    #1 chk("haz_in_ready", 0, 64'(d_rdy[0]), 64'h0);
    step();
    chk("haz_bubble", 0, 64'(d_val[0]), 64'h0);
    ex_mem_read = 0;
    #1 chk("haz_release", 0, 64'(d_rdy[0]), 64'h1);
    step();
    chk("haz_accept", 0, 64'(d_val[0]), 64'h1);
    chk("haz_rs1", 0, 64'(d_rs1[0]), 64'h1234);

    // BEQ x1,x2,-8 held under backpressure
    instr_in = 32'hFE20_8CE3; pc_in = 32'h10C;
    step();
    out_ready = 0; instr_in = 32'h0051_8213; pc_in = 32'h110;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 0, 64'(d_rdy[0]), 64'h0);
      step();
      chk("bp_imm", 0, 64'(d_imm[0]), 64'hFFFF_FFF8);
      chk("bp_pc", 0, 64'(d_pc[0]), 64'h10C);
    end
    out_ready = 1;
    step();

    // SW in the register, then flush with LW on the input
    instr_in = 32'h0020_A023; pc_in = 32'h114;
    step();
    chk("sw_mem_write", 0, 64'(d_mw[0]), 64'h1);
    out_ready = 0; flush = 1; instr_in = 32'h0040_A383; pc_in = 32'h118;
    #1 chk("flush_in_ready", 0, 64'(d_rdy[0]), 64'h1);
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    chk("flush_valid", 0, 64'(d_val[0]), 64'h0);
    step();
    chk("lw_dropped", 0, 64'(d_val[0]), 64'h0);

    // unsupported opcode, then RV32E out-of-range rd
    in_valid = 1; instr_in = 32'h0000_000F; pc_in = 32'h11C;
    step();
    chk("fence_illegal", 0, 64'(d_ill[0]), 64'h1);
    chk("fence_rdw", 0, 64'(d_rdw[0]), 64'h0);
    chk("fence_valid", 0, 64'(d_val[0]), 64'h1);
    instr_in = 32'h0020_88B3; pc_in = 32'h120;
    step();
    chk("rv32e_illegal", 2, 64'(d_ill[2]), 64'h1);
    chk("rv32e_rdw", 2, 64'(d_rdw[2]), 64'h0);
    chk("rv32i_legal", 0, 64'(d_ill[0]), 64'h0);
    in_valid = 0;
    step();

    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 299) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      in_valid    = ($urandom_range(0, 9) < 7);
      instr_in    = rand_instr();
      pc_in       = $urandom & 32'hFFFF_FFFC;
      out_ready   = ($urandom_range(0, 9) < 7);
      wb_write    = 1'($urandom_range(0, 1));
      wb_rd       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wb_value    = $urandom;
      ex_mem_read = ($urandom_range(0, 9) < 3);
      ex_rd       = 5'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised successor of the single-issue RV32I decode stage.
- Decodes one instruction per cycle into a registered ID/EX payload with a valid/ready handshake on both sides.
- Embeds the integer register file, with write-back-to-decode bypass.
- Detects load-use hazards against EX, honours branch flush, and flags illegal or unsupported encodings instead of silently passing them.
- Sits between fetch (upstream) and the ALU/EX stage (downstream).

Parameters:
- XLEN, 32: datapath width of register values, PC and immediate. Legal values: 32, 64; 64 sign-extends immediates to 64.
- NREGS, 32: architectural registers. 32 is RV32I; 16 is RV32E, where any rs1/rs2/rd index >= 16 is illegal.
- BYPASS, 1: 1 forwards a same-cycle write-back to decode reads; 0 returns the pre-write array value.

Ports:
- req  in  1: clock, rising edge.
- reset  in  1: synchronous, active-high.
- in_valid  in  1: fetch presents instr_in/pc_in.
- in_ready  out  1: decode accepts this cycle.
- instr_in  in  32: instruction word.
- pc_in  in  XLEN: PC of instr_in.
- wb_write  in  1: write-back enable.
- wb_rd  in  5: write-back destination.
- wb_value  in  XLEN: write-back data.
- ex_mem_read  in  1: instruction currently in EX is a load.
- ex_rd  in  5: destination of the instruction in EX.
- flush  in  1: squash decode contents and the input beat.
- out_valid  out  1: payload valid.
- out_ready  in  1: EX accepts payload.
- pc_out  out  XLEN: registered PC.
- funct3_out  out  3: registered funct3.
- funct7_out  out  7: registered funct7.
- alu_op_out  out  7: registered opcode[6:0].
- rd_out  out  5: registered destination index.
- rd_write_out  out  1: registered register-write enable.
- mem_read_out  out  1: registered load flag.
- mem_write_out  out  1: registered store flag.
- rs1_value_out  out  XLEN: registered rs1 value.
- rs2_value_out  out  XLEN: registered rs2 value.
- imm_value_out  out  XLEN: registered sign-extended immediate.
- illegal_out  out  1: registered illegal/unsupported flag.

Behaviour:
- Reset, synchronous: every output register, including out_valid, clears to 0; all register-file entries clear to 0. Reset overrides flush, hazard and write-back in the same cycle.
- Latency: 1 cycle from accepted input to out_valid.
- Register advance: adv = !out_valid || out_ready.
- Ready: in_ready = adv && !hazard; forced to 1 when flush = 1.
- Accepted beat (in_valid && in_ready && !flush): capture the payload, out_valid <= 1.
- Bubble: when adv && (!in_valid || hazard), out_valid <= 0 and payload fields hold their values.
- Backpressure: while out_valid && !out_ready, all outputs are held stable bit-for-bit.
- Flush: out_valid <= 0 next edge. Any input beat presented that cycle is consumed and dropped. Flush beats hazard.
- Hazard: in_valid && ex_mem_read && ex_rd != 0 && ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd)).
  - uses_rs1 for R, I-op, load, store, branch, JALR.
  - uses_rs2 for R, store, branch only.
- Register read is combinational inside the stage.
  - x0 always reads 0.
  - With BYPASS=1: if wb_write && wb_rd == rs && rs != 0, return wb_value.
  - Writes to x0 are ignored.
  - The write takes effect at the edge, including during stall or flush.
- Supported opcodes: R 0110011, I-op 0010011, load 0000011, store 0100011, branch 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- Immediate formats: I, S, B (bit0 = 0), U (low 12 bits = 0), J (bit0 = 0). Sign-extended to XLEN. R-type immediate is 0.
- rd_write = 1 for R, I-op, load, LUI, AUIPC, JAL, JALR. Forced to 0 when rd == 0.
- Illegal conditions:
  - unsupported opcode, or instr_in[1:0] != 11;
  - NREGS=16 with any used index >= 16.
  - When illegal: illegal_out = 1, rd_write_out = 0, mem_read_out = 0, mem_write_out = 0, out_valid = 1 (the trap is taken downstream).
- Unused rs2 field: rs2_value_out = 0 when !uses_rs2, so the field is never X.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams;
  - imm_fmt_e enum (IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J);
  - ctrl_t struct (uses_rs1, uses_rs2, rd_write, mem_read, mem_write, illegal, imm_fmt);
  - function decode_ctrl(opcode) returning ctrl_t.
- One sub-module, regfile_bypass (params XLEN, NREGS, BYPASS): two combinational read ports and one write port, clocked by req, cleared on reset.
- Immediate generation and hazard logic stay in decode_stage.

Test Plan:
- Reset for 2 cycles, then release -> out_valid = 0, all outputs 0, in_ready = 1. Read of x5 returns 0.
- wb write x3 = 0x1234 on cycle N, ADDI x4,x3,5 (0x00518213) presented on cycle N -> next cycle rs1_value_out = 0x1234, imm_value_out = 5, rd_out = 4. Repeat with BYPASS=0 -> rs1_value_out = 0.
- ex_mem_read = 1 with ex_rd = 3, ADD x5,x3,x1 presented -> in_ready = 0, out_valid = 0 next cycle. When ex_mem_read drops -> accepted.
- out_ready = 0 for 3 cycles with BEQ (imm -8) held in the register -> outputs stable, imm_value_out = 0xFFFFFFF8, in_ready = 0.
- flush asserted with SW in the output register and LW on the input -> out_valid = 0 next edge, LW dropped.
- Opcode 0001111 -> illegal_out = 1, rd_write_out = 0. With NREGS=16, ADD x17,x1,x2 -> illegal_out = 1.
